// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_ctrl_pkg : shared state encoding, divider codes and defaults for the  |
// | CPU clock-speed policy logic.                               Rev 1.0       |
// +----------------------------------------------------------------------------+
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    LS_RUN = 2'b00,
    HS_REQ = 2'b01,
    HS_RUN = 2'b10,
    LS_REQ = 2'b11
  } clk_state_e;

  localparam logic [1:0] DIV1 = 2'b00;
  localparam logic [1:0] DIV2 = 2'b01;

  localparam int DEF_MIN_LS_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Any request other than /1 collapses to /2, the only other supported ratio.
  function automatic logic [1:0] div_code(input logic [1:0] cfg);
    return (cfg == DIV1) ? DIV1 : DIV2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_speed_ctrl_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync2 : two-flop async-reset synchroniser into the host clock domain.     |
// |                                                             Rev 1.0       |
// +----------------------------------------------------------------------------+
module sync2 (
  input  logic clk_i,
  input  logic rst_b_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/clk_speed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_speed_ctrl : HS/LS clock policy FSM for the CPU clock switcher.       |
// | Optional HS_REQ watchdog with macro CLK_WDOG_EN.            Rev 1.0       |
// +----------------------------------------------------------------------------+
module clk_speed_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int MIN_LS_CYCLES  = DEF_MIN_LS_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       turbo_en,
  input  logic       need_ls,
  input  logic [1:0] cfg_div_sel,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  input  logic       err_clr,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       hs_active,
  output logic       io_pending,
  output logic       hs_timeout_err
);

  localparam int              HW        = $clog2(MIN_LS_CYCLES + 1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(MIN_LS_CYCLES);

  clk_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    div_q, div_d;
  logic          hs_ack;
  logic          wd_expired;
  logic          wdog_err;
  logic          err_set;

  sync2 u_ack_sync (
    .clk_i   (lsclk_in),
    .rst_b_i (rst_b),
    .d_i     (hsclk_selected),
    .q_o     (hs_ack)
  );

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= LS_RUN;
      hold_q  <= HOLD_INIT;
      div_q   <= DIV1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    err_set = 1'b0;
    case (state_q)
      LS_RUN: begin
        div_d = div_code(cfg_div_sel);
        if (hold_q != '0) hold_d = hold_q - HW'(1);
        if (turbo_en && !need_ls && (hold_q == '0) && !wdog_err) state_d = HS_REQ;
      end
      HS_REQ: begin
        // Abort beats ack, ack beats watchdog expiry.
        if (need_ls || !turbo_en) begin
          state_d = LS_REQ;
        end else if (hs_ack) begin
          state_d = HS_RUN;
        end else if (wd_expired) begin
          state_d = LS_REQ;
          err_set = 1'b1;
        end
      end
      HS_RUN: begin
        if (need_ls || !turbo_en) state_d = LS_REQ;
      end
      LS_REQ: begin
        if (lsclk_selected && !hs_ack) begin
          state_d = LS_RUN;
          hold_d  = HOLD_INIT;
        end
      end
      default: state_d = LS_REQ;
    endcase
  end

`ifdef CLK_WDOG_EN
  localparam int            WW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Counter idles at zero outside HS_REQ, so every entry starts a fresh window.
  always_comb begin
    wd_d = '0;
    if (state_q == HS_REQ && wd_q != WD_MAX) wd_d = wd_q + WW'(1);
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign wd_expired = (state_q == HS_REQ) && (wd_q == WD_MAX);
  assign wdog_err   = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_wdog;

  assign unused_wdog = err_clr | err_set;
  assign wd_expired  = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  assign hsclk_sel      = (state_q == HS_REQ) || (state_q == HS_RUN);
  assign hs_active      = (state_q == HS_RUN);
  assign io_pending     = need_ls && (state_q != LS_RUN);
  assign cpuclk_div_sel = div_q;
  assign hs_timeout_err = wdog_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_speed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clk_speed_ctrl : directed + randomized bench with behavioural model.   |
// |                                                             Rev 1.0       |
// +----------------------------------------------------------------------------+
module tb_clk_speed_ctrl;

  localparam int MIN_LS = 4;
  localparam int TMO    = 64;
`ifdef CLK_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  localparam int M_LS    = 0;
  localparam int M_HREQ  = 1;
  localparam int M_HRUN  = 2;
  localparam int M_LSREQ = 3;

  logic       lsclk_in = 1'b0;
  logic       rst_b    = 1'b1;
  logic       turbo_en = 1'b0;
  logic       need_ls  = 1'b0;
  logic [1:0] cfg_div_sel = 2'b00;
  logic       hsclk_selected = 1'b0;
  logic       lsclk_selected = 1'b1;
  logic       err_clr  = 1'b0;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       hs_active;
  logic       io_pending;
  logic       hs_timeout_err;

  int total = 0;
  int bad   = 0;

  clk_speed_ctrl #(
    .MIN_LS_CYCLES  (MIN_LS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .lsclk_in       (lsclk_in),
    .rst_b          (rst_b),
    .turbo_en       (turbo_en),
    .need_ls        (need_ls),
    .cfg_div_sel    (cfg_div_sel),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .err_clr        (err_clr),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .hs_active      (hs_active),
    .io_pending     (io_pending),
    .hs_timeout_err (hs_timeout_err)
  );

  always #5 lsclk_in = ~lsclk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode, cycles left in the dwell window, ack delayed two edges.
  int         m_mode, m_hold, m_wd;
  bit         m_s1, m_s2, m_ack, m_err, m_old_err, m_abort;
  logic [1:0] m_div;

  always @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      m_mode = M_LS; m_hold = MIN_LS; m_wd = 0;
      m_s1 = 0; m_s2 = 0; m_err = 0; m_div = 2'b00;
    end else begin
      m_ack = m_s2; m_s2 = m_s1; m_s1 = hsclk_selected;
      m_abort = need_ls || !turbo_en;
      m_old_err = m_err;
      if (err_clr) m_err = 0;
      case (m_mode)
        M_LS: begin
          m_div = (cfg_div_sel == 2'b00) ? 2'b00 : 2'b01;
          if (turbo_en && !need_ls && m_hold == 0 && !m_old_err) begin
            m_mode = M_HREQ; m_wd = 0;
          end
          if (m_hold > 0) m_hold = m_hold - 1;
        end
        M_HREQ: begin
          m_wd = m_wd + 1;
          if (m_abort) m_mode = M_LSREQ;
          else if (m_ack) m_mode = M_HRUN;
          else if (WDOG && m_wd >= TMO) begin m_mode = M_LSREQ; m_err = 1; end
        end
        M_HRUN: if (m_abort) m_mode = M_LSREQ;
        default: if (lsclk_selected && !m_ack) begin m_mode = M_LS; m_hold = MIN_LS; end
      endcase
    end
  end

  always @(negedge lsclk_in) begin
    chk("cyc_hsclk_sel", 32'(hsclk_sel), 32'(m_mode == M_HREQ || m_mode == M_HRUN));
    chk("cyc_hs_active", 32'(hs_active), 32'(m_mode == M_HRUN));
    chk("cyc_io_pending", 32'(io_pending), 32'(need_ls && m_mode != M_LS));
    chk("cyc_div", 32'(cpuclk_div_sel), 32'(m_div));
    chk("cyc_err", 32'(hs_timeout_err), 32'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge lsclk_in);
    #2;
  endtask

  // Reset from wherever we are; HS must be requested on the 5th edge after release.
  task automatic reset_seq(input string tag);
    rst_b = 1'b0;
    #1;
    chk({tag, "_rst_hsclk_sel"}, 32'(hsclk_sel), 32'd0);
    chk({tag, "_rst_div"}, 32'(cpuclk_div_sel), 32'd0);
    chk({tag, "_rst_err"}, 32'(hs_timeout_err), 32'd0);
    #1 rst_b = 1'b1;
    tick(4);
    chk({tag, "_hold_edge4"}, 32'(hsclk_sel), 32'd0);
    tick(1);
    chk({tag, "_hold_edge5"}, 32'(hsclk_sel), 32'd1);
  endtask

  bit stuck = 1'b0;

  initial begin
    #1 rst_b = 1'b0;
    turbo_en = 1'b1;
    tick(1);
    reset_seq("t1");

    hsclk_selected = 1'b1; lsclk_selected = 1'b0;
    tick(2);
    chk("t2_active_e2", 32'(hs_active), 32'd0);
    tick(1);
    chk("t2_active_e3", 32'(hs_active), 32'd1);
    chk("t2_hsclk_sel", 32'(hsclk_sel), 32'd1);

    cfg_div_sel = 2'b01;
    tick(2);
    chk("t4_div_in_hs", 32'(cpuclk_div_sel), 32'd0);
    need_ls = 1'b1;
    tick(1);
    chk("t3_drop_hsclk_sel", 32'(hsclk_sel), 32'd0);
    chk("t3_io_pending", 32'(io_pending), 32'd1);
    tick(3);
    chk("t3_wait_lsreq", 32'(io_pending), 32'd1);
    lsclk_selected = 1'b1; hsclk_selected = 1'b0;
    tick(2);
    chk("t3_ack_draining", 32'(io_pending), 32'd1);
    tick(1);
    chk("t3_ls_run_io", 32'(io_pending), 32'd0);
    chk("t4_div_entry", 32'(cpuclk_div_sel), 32'd0);
    tick(1);
    chk("t4_div_loaded", 32'(cpuclk_div_sel), 32'd1);
    need_ls = 1'b0;
    tick(3);
    chk("t3_holdoff", 32'(hsclk_sel), 32'd0);
    tick(1);
    chk("t3_rerequest", 32'(hsclk_sel), 32'd1);

    hsclk_selected = 1'b1;
    tick(2);
    need_ls = 1'b1;
    tick(1);
    chk("t5_abort_active", 32'(hs_active), 32'd0);
    chk("t5_abort_hsclk_sel", 32'(hsclk_sel), 32'd0);

    hsclk_selected = 1'b0; need_ls = 1'b0;
    tick(3);
    reset_seq("mid0");
    hsclk_selected = 1'b1;
    tick(2);
    hsclk_selected = 1'b0;
    reset_seq("midhs");

`ifdef CLK_WDOG_EN
    tick(63);
    chk("t6_before_tmo", 32'(hsclk_sel), 32'd1);
    tick(1);
    chk("t6_tmo_hsclk_sel", 32'(hsclk_sel), 32'd0);
    chk("t6_tmo_err", 32'(hs_timeout_err), 32'd1);
    tick(10);
    chk("t6_blocked", 32'(hsclk_sel), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t6_cleared", 32'(hs_timeout_err), 32'd0);
    tick(1);
    chk("t6_rerequest", 32'(hsclk_sel), 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      tick(1);
      turbo_en    = ($urandom % 10) != 0;
      need_ls     = ($urandom % 6) == 0;
      cfg_div_sel = 2'($urandom);
      err_clr     = ($urandom % 25) == 0;
      if ($urandom % 100 == 0) stuck = !stuck;
      if (hsclk_sel && !hsclk_selected && !stuck && ($urandom % 3 == 0))
        hsclk_selected = 1'b1;
      else if (!hsclk_sel && hsclk_selected && ($urandom % 3 == 0))
        hsclk_selected = 1'b0;
      lsclk_selected = ($urandom % 10 == 0) ? 1'($urandom) : !hsclk_selected;
      if ($urandom % 400 == 0) begin
        #1 rst_b = 1'b0;
        #1 rst_b = 1'b1;
      end
    end

    tick(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_speed_ctrl.md
Name: clk_speed_ctrl

Overview:
- Upstream policy stage for the CPU clock switcher; runs entirely on host clock lsclk_in.
- Decides when the CPU may run from the high-speed clock and when it must drop to the host clock for I/O or host-memory cycles.
- Drives the switcher's hsclk_sel and cpuclk_div_sel, and consumes its hsclk_selected/lsclk_selected status as a request/acknowledge handshake.
- Enforces a minimum dwell time in low-speed mode to prevent clock thrash.

Parameters:
MIN_LS_CYCLES, 4, lsclk cycles held in LS_RUN after any return to low speed before HS may be re-requested (>=1)
TIMEOUT_CYCLES, 64, lsclk cycles allowed in HS_REQ before watchdog fires (only with CLK_WDOG_EN)

Ports:
lsclk_in  input  1  host clock; all state updates on posedge
rst_b  input  1  asynchronous active-low reset
turbo_en  input  1  config: high-speed operation permitted
need_ls  input  1  address decode says current access needs host timing; stable at posedge lsclk_in
cfg_div_sel  input  2  requested HS divider (00 = /1, 01 = /2)
hsclk_selected  input  1  switcher status, CPU-clock domain
lsclk_selected  input  1  switcher status, lsclk domain
err_clr  input  1  clears watchdog error (ignored without CLK_WDOG_EN)
hsclk_sel  output  1  request to switcher
cpuclk_div_sel  output  2  divider select to switcher
hs_active  output  1  state == HS_RUN
io_pending  output  1  need_ls && state != LS_RUN
hs_timeout_err  output  1  sticky watchdog flag (constant 0 without CLK_WDOG_EN)

Behaviour:
- Reset values:
  - FSM in LS_RUN.
  - hsclk_sel=0, cpuclk_div_sel=00, hs_active=0, io_pending=0, hs_timeout_err=0.
  - Holdoff counter = MIN_LS_CYCLES; sync flops = 0.
- Synchronisation:
  - hs_ack = hsclk_selected through a 2-flop synchroniser on posedge lsclk_in.
  - lsclk_selected is used directly; it is already in the lsclk domain.
- States, all registered with one-cycle latency; hsclk_sel decoded from state (1 in HS_REQ and HS_RUN):
  - LS_RUN: holdoff decrements by 1 per cycle while >0, saturating at 0. Go to HS_REQ when turbo_en && !need_ls && holdoff==0.
  - HS_REQ: go to HS_RUN when hs_ack==1. If need_ls || !turbo_en, abort to LS_REQ; abort has priority over ack on the same edge.
  - HS_RUN: go to LS_REQ when need_ls || !turbo_en.
  - LS_REQ: go to LS_RUN when lsclk_selected==1 && hs_ack==0. On that edge, reload holdoff with MIN_LS_CYCLES.
- Minimum latency, from the edge sampling the HS condition to the first edge in HS_RUN: 1 cycle to HS_REQ plus 2 synchroniser cycles after hsclk_selected rises.
- cpuclk_div_sel:
  - Loads cfg_div_sel only on edges where the FSM is in LS_RUN; frozen in all other states.
  - The divider therefore never changes while the HS path may be enabled.
  - cfg_div_sel values 1x load as 01.
- io_pending is combinational from need_ls and the state register.
- Dwell counter width: $clog2(MIN_LS_CYCLES+1).
- Reset mid-handshake: returns immediately to LS_RUN, hsclk_sel=0, full holdoff reloaded.
- Illegal state encodings recover to LS_REQ.

Optional Feature:
- Macro CLK_WDOG_EN.
- With CLK_WDOG_EN:
  - A counter runs while in HS_REQ; it is cleared on entry to HS_REQ.
  - On reaching TIMEOUT_CYCLES without ack: FSM goes to LS_REQ and hs_timeout_err sets.
  - While hs_timeout_err=1, the LS_RUN->HS_REQ transition is blocked.
  - err_clr=1 clears the flag on the next edge; set wins over simultaneous clear.
- Without CLK_WDOG_EN: no counter is built, hs_timeout_err is tied to 0, err_clr is unused, and HS_REQ waits indefinitely.

Decomposition:
- Shared package clk_ctrl_pkg:
  - State encoding constants for LS_RUN/HS_REQ/HS_RUN/LS_REQ.
  - Divider select codes DIV1=00 and DIV2=01.
  - Default MIN_LS_CYCLES and TIMEOUT_CYCLES.
- One sub-module, sync2: a 2-flop async-reset synchroniser used for hsclk_selected.

Test Plan:
1. Reset with turbo_en=1, need_ls=0 -> hsclk_sel=0 and cpuclk_div_sel=00 during reset; hsclk_sel=1 on the 5th posedge after release (MIN_LS_CYCLES=4).
2. In HS_REQ, raise hsclk_selected -> hs_active=1 on the 3rd following posedge; hsclk_sel stays 1.
3. In HS_RUN, set need_ls=1 -> hsclk_sel=0 and io_pending=1 next edge; hold lsclk_selected=0 for 3 cycles -> stays LS_REQ; drive lsclk_selected=1, hsclk_selected=0 -> LS_RUN, io_pending=0; next HS request no earlier than 4 cycles later.
4. cfg_div_sel=01 applied during HS_RUN -> cpuclk_div_sel stays 00 until the first edge in LS_RUN, then 01.
5. need_ls=1 on the same edge hs_ack rises in HS_REQ -> LS_REQ, hs_active never asserts.
6. (CLK_WDOG_EN, TIMEOUT_CYCLES=64) never ack -> after 64 cycles hs_timeout_err=1 and hsclk_sel=0; FSM stays LS until an err_clr pulse, then re-requests after holdoff.
